// File: rtl/usb_reg_bus_master.sv
// Bus initiator for the CW305 parallel USB register bus: turns burst read/write
// commands into one byte-wide usb_addr/usb_din/rdn/wrn/cen transaction per byte.
module usb_reg_bus_master #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pRD_LAT       = 4   // read strobe width in cycles, must be >= 3
) (
  input  logic                                 usb_clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_write,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_reg,
  input  logic [pBYTECNT_SIZE-1:0]             cmd_len,
  input  logic [7:0]                           wr_data,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  output logic [7:0]                           rd_data,
  output logic                                 rd_valid,
  output logic                                 busy,
  output logic                                 err_contention,
  output logic [pADDR_WIDTH-1:0]               bus_addr,
  output logic [7:0]                           bus_dout,
  output logic                                 bus_dout_en,
  input  logic [7:0]                           bus_din,
  input  logic                                 bus_isout,
  output logic                                 bus_rdn,
  output logic                                 bus_wrn,
  output logic                                 bus_cen
);

  localparam int REG_W = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int CNT_W = $clog2(pRD_LAT + 1);

  localparam logic [pBYTECNT_SIZE-1:0] IDX_ZERO = {pBYTECNT_SIZE{1'b0}};
  localparam logic [pBYTECNT_SIZE-1:0] IDX_ONE  = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]         CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]         CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(pRD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_SETUP  = 3'd4,
    R_STROBE = 3'd5,
    R_GAP    = 3'd6
  } state_t;

  state_t                   state_r;
  logic [REG_W-1:0]         reg_r;
  logic [pBYTECNT_SIZE-1:0] len_r;
  logic [pBYTECNT_SIZE-1:0] idx_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [pBYTECNT_SIZE-1:0] idx_next_s;

  // idx never exceeds len_r, so this increment cannot wrap within a burst
  assign idx_next_s = idx_r + IDX_ONE;

  // Bus sequencer: burst bookkeeping, strobe timing and all registered outputs
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      reg_r          <= '0;
      len_r          <= IDX_ZERO;
      idx_r          <= IDX_ZERO;
      cnt_r          <= CNT_ZERO;
      cmd_ready      <= 1'b0;
      wr_ready       <= 1'b0;
      rd_data        <= 8'h00;
      rd_valid       <= 1'b0;
      busy           <= 1'b0;
      err_contention <= 1'b0;
      bus_addr       <= '0;
      bus_dout       <= 8'h00;
      bus_dout_en    <= 1'b0;
      bus_rdn        <= 1'b1;
      bus_wrn        <= 1'b1;
      bus_cen        <= 1'b1;
    end else begin
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      if (bus_dout_en && bus_isout) begin
        err_contention <= 1'b1;
      end else begin
        err_contention <= err_contention;
      end

      case (state_r)
        IDLE: begin
          cmd_ready <= 1'b1;
          bus_cen   <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            reg_r          <= cmd_reg;
            len_r          <= cmd_len;
            idx_r          <= IDX_ZERO;
            err_contention <= 1'b0;
            cmd_ready      <= 1'b0;
            busy           <= 1'b1;
            bus_cen        <= 1'b0;
            bus_addr       <= {cmd_reg, IDX_ZERO};
            if (cmd_write) begin
              bus_dout_en <= 1'b1;
              state_r     <= W_SETUP;
            end else begin
              bus_dout_en <= 1'b0;
              state_r     <= R_SETUP;
            end
          end
        end

        W_SETUP: begin
          // stall here with strobes idle until the source has a byte
          if (wr_valid) begin
            wr_ready <= 1'b1;
            bus_dout <= wr_data;
            bus_wrn  <= 1'b0;
            state_r  <= W_STROBE;
          end else begin
            bus_wrn  <= 1'b1;
          end
        end

        W_STROBE: begin
          bus_wrn <= 1'b1;
          state_r <= W_HOLD;
        end

        W_HOLD: begin
          if (idx_r == len_r) begin
            bus_cen     <= 1'b1;
            bus_dout_en <= 1'b0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            state_r     <= IDLE;
          end else begin
            idx_r    <= idx_next_s;
            bus_addr <= {reg_r, idx_next_s};
            state_r  <= W_SETUP;
          end
        end

        R_SETUP: begin
          bus_rdn <= 1'b0;
          cnt_r   <= CNT_ZERO;
          state_r <= R_STROBE;
        end

        R_STROBE: begin
          // sample on the final strobe cycle to give the responder its full latency
          if (cnt_r == CNT_LAST) begin
            rd_data  <= bus_din;
            rd_valid <= 1'b1;
            bus_rdn  <= 1'b1;
            state_r  <= R_GAP;
          end else begin
            cnt_r    <= cnt_r + CNT_ONE;
          end
        end

        R_GAP: begin
          if (idx_r == len_r) begin
            bus_cen   <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            idx_r    <= idx_next_s;
            bus_addr <= {reg_r, idx_next_s};
            state_r  <= R_SETUP;
          end
        end

        default: begin
          bus_rdn     <= 1'b1;
          bus_wrn     <= 1'b1;
          bus_cen     <= 1'b1;
          bus_dout_en <= 1'b0;
          busy        <= 1'b0;
          cmd_ready   <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_reg_bus_master.sv
// Scoreboard bench for usb_reg_bus_master: expected bus writes and read bytes are
// queued by the stimulus, and a negedge monitor pops and compares them.
module tb_usb_reg_bus_master;

  localparam int AW = 21;
  localparam int BW = 7;
  localparam int RW = AW - BW;

  logic          usb_clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [RW-1:0] cmd_reg;
  logic [BW-1:0] cmd_len;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          busy;
  logic          err_contention;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_dout;
  logic          bus_dout_en;
  logic [7:0]    bus_din = 8'h00;
  logic          bus_isout;
  logic          bus_rdn;
  logic          bus_wrn;
  logic          bus_cen;

  usb_reg_bus_master #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW), .pRD_LAT(4)) dut (
    .usb_clk(usb_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .err_contention(err_contention),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_dout_en(bus_dout_en),
    .bus_din(bus_din), .bus_isout(bus_isout),
    .bus_rdn(bus_rdn), .bus_wrn(bus_wrn), .bus_cen(bus_cen)
  );

  always #5 usb_clk = ~usb_clk;

  logic [AW-1:0] exp_wa[$];
  logic [7:0]    exp_wd[$];
  logic [7:0]    exp_rd[$];
  logic [7:0]    src_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_cen_low = 0;
  int last_rd_cyc = 0;
  int rd_have_prev = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [7:0] rsp_d1 = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge usb_clk) cyc <= cyc + 1;

  // Responder: returns addr[7:0] two cycles after seeing rdn low
  always @(posedge usb_clk) begin
    rsp_d1  <= (bus_rdn == 1'b0) ? bus_addr[7:0] : 8'h00;
    bus_din <= rsp_d1;
  end

  // Write-data source: presents the head of src_q, advances on wr_ready
  initial begin
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(negedge usb_clk);
      if (wr_ready === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
      wr_valid = (src_q.size() > 0);
      wr_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  // Monitor: compares every write strobe and read byte against the scoreboard
  initial begin
    forever begin
      @(negedge usb_clk);
      if (bus_cen === 1'b0) n_cen_low++;
      if (bus_wrn === 1'b0) begin
        n_strobe++;
        last_wr_addr = bus_addr;
        check("wr_strobe_expected", (exp_wa.size() > 0), 1);
        check("wr_strobe_cen", bus_cen, 0);
        if (exp_wa.size() > 0) begin
          check("wr_addr", bus_addr, exp_wa.pop_front());
          check("wr_data", bus_dout, exp_wd.pop_front());
        end
      end
      if (rd_valid === 1'b1) begin
        check("rd_valid_expected", (exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
        if (rd_have_prev != 0) check("rd_spacing", cyc - last_rd_cyc, 6);
        last_rd_cyc  = cyc;
        rd_have_prev = 1;
      end
    end
  end

  task automatic issue(input logic w, input logic [RW-1:0] r, input logic [BW-1:0] l);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 200) begin
      @(negedge usb_clk);
      t++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_reg   = r;
    cmd_len   = l;
    @(negedge usb_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while (!(busy === 1'b0 && cmd_ready === 1'b1) && t < budget) begin
      @(negedge usb_clk);
      t++;
    end
    check(name, (busy === 1'b0 && cmd_ready === 1'b1), 1);
  endtask

  task automatic clear_counts();
    n_strobe     = 0;
    n_cen_low    = 0;
    rd_have_prev = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_reg = '0; cmd_len = '0;
    bus_isout = 1'b0;
    repeat (3) @(negedge usb_clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {bus_rdn, bus_wrn, bus_cen}, 3'b111);
    check("rst_dout_en", bus_dout_en, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_err", err_contention, 0);
    check("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    @(negedge usb_clk);
    check("ready_after_reset", cmd_ready, 1);

    // single write: 0x05 << 7 = 0x280
    src_q.push_back(8'hA5);
    exp_wa.push_back(21'h000280); exp_wd.push_back(8'hA5);
    clear_counts();
    issue(1'b1, 14'h0005, 7'd0);
    wait_idle("single_write_done", 50);
    check("single_write_strobes", n_strobe, 1);
    check("single_write_cen_cycles", n_cen_low, 3);
    check("single_write_dout_en_off", bus_dout_en, 0);

    // 4-byte read from reg 0x01 -> addresses 0x80..0x83
    for (int i = 0; i < 4; i++) exp_rd.push_back(8'h80 + 8'(i));
    clear_counts();
    issue(1'b0, 14'h0001, 7'd3);
    wait_idle("read4_done", 100);
    check("read4_cen_cycles", n_cen_low, 24);
    check("read4_all_delivered", exp_rd.size(), 0);

    // 3-byte write with the source stalling before byte 1
    src_q.push_back(8'h11);
    exp_wa.push_back({14'h0123, 7'd0}); exp_wd.push_back(8'h11);
    exp_wa.push_back({14'h0123, 7'd1}); exp_wd.push_back(8'h22);
    exp_wa.push_back({14'h0123, 7'd2}); exp_wd.push_back(8'h33);
    clear_counts();
    issue(1'b1, 14'h0123, 7'd2);
    repeat (3) @(negedge usb_clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_wrn_high", bus_wrn, 1);
      check("stall_cen_low", bus_cen, 0);
      check("stall_addr_idx", bus_addr[6:0], 7'd1);
      @(negedge usb_clk);
    end
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    wait_idle("stall_write_done", 100);
    check("stall_write_strobes", n_strobe, 3);
    check("stall_write_drained", exp_wa.size(), 0);

    // 128-byte write: idx 0..127 with no wrap
    for (int i = 0; i < 128; i++) begin
      src_q.push_back(8'(i * 5 + 3));
      exp_wa.push_back({14'h01A5, 7'(i)});
      exp_wd.push_back(8'(i * 5 + 3));
    end
    clear_counts();
    issue(1'b1, 14'h01A5, 7'd127);
    wait_idle("long_write_done", 1000);
    check("long_write_strobes", n_strobe, 128);
    check("long_write_cen_cycles", n_cen_low, 384);
    check("long_write_last_addr", last_wr_addr, {14'h01A5, 7'h7F});
    check("long_write_drained", exp_wa.size(), 0);

    // responder contention during a write, cleared by the next command
    bus_isout = 1'b1;
    src_q.push_back(8'h5A);
    exp_wa.push_back({14'h0013, 7'd0}); exp_wd.push_back(8'h5A);
    issue(1'b1, 14'h0013, 7'd0);
    wait_idle("contention_write_done", 50);
    bus_isout = 1'b0;
    check("contention_set", err_contention, 1);
    @(negedge usb_clk);
    check("contention_sticky", err_contention, 1);
    exp_rd.push_back(8'h80);
    clear_counts();
    issue(1'b0, 14'h0013, 7'd0);
    check("contention_cleared", err_contention, 0);
    wait_idle("contention_read_done", 50);
    check("contention_read_drained", exp_rd.size(), 0);

    // reset in the middle of byte 2's read strobe
    exp_rd.push_back(8'h80);
    exp_rd.push_back(8'h81);
    clear_counts();
    issue(1'b0, 14'h0003, 7'd3);
    begin
      int t = 0;
      while (!(bus_addr[6:0] == 7'd2 && bus_rdn === 1'b0) && t < 100) begin
        @(negedge usb_clk);
        t++;
      end
      check("reach_byte2_strobe", (bus_addr[6:0] == 7'd2 && bus_rdn === 1'b0), 1);
    end
    @(negedge usb_clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rdn", bus_rdn, 1);
    check("async_rst_cen", bus_cen, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cmd_ready, 0);
    repeat (2) @(negedge usb_clk);
    rst = 1'b0;
    @(negedge usb_clk);
    check("ready_after_midburst_reset", cmd_ready, 1);
    check("midburst_bytes_delivered", exp_rd.size(), 0);
    repeat (10) @(negedge usb_clk);
    check("no_strobe_after_reset", bus_rdn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
